// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Includes the address-width derivation and the packed-bus slice offsets.
package regfile_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  // A single-entry file still needs one address bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Low bit of port k inside a packed bus whose per-port field is w bits wide.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Port bundle between decode/writeback and the register file.
// Holds the read, write and reserve buses plus the scoreboard status outputs.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
);
  localparam int AW = calc_aw(DEPTH);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_err;
  logic [AW:0]          busy_cnt;

  // wr_en and rsv_en are single-cycle strobes with no ready: every asserted
  // strobe is taken at the next rising edge, and reads are always valid.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_err, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_err, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, new reservation wins.
// Also produces the registered double-reserve error pulse and the busy population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [DEPTH-1:0]     busy,
  output logic                 rsv_err,
  output logic [AW:0]          busy_cnt
);

  logic [DEPTH-1:0] clr;
  logic [DEPTH-1:0] set;
  logic [DEPTH-1:0] busy_nxt;
  logic             rsv_ok;
  logic             err_nxt;
  logic [AW:0]      cnt_nxt;

  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  always_comb begin
    clr = '0;
    set = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) clr[wr_addr[slice_lo(i, AW) +: AW]] = 1'b1;
    end
    if (rsv_ok) set[rsv_addr] = 1'b1;
    // Set is applied after clear so a same-cycle reservation survives its writeback.
    busy_nxt = (busy & ~clr) | set;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    err_nxt = rsv_ok && busy[rsv_addr] && !clr[rsv_addr];
    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      rsv_err  <= 1'b0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      rsv_err  <= err_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and a busy scoreboard.
// Storage, write-port priority and read/bypass muxes live here; busy tracking is delegated.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic            clk,
  input logic            rst_n,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = calc_aw(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;

  // Ascending port order makes the highest-indexed port the last (winning) write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] &&
            !((ZERO_REG != 0) && (bus.wr_addr[slice_lo(i, AW) +: AW] == '0))) begin
          mem[bus.wr_addr[slice_lo(i, AW) +: AW]] <= bus.wr_data[slice_lo(i, DW) +: DW];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] d;
    logic          hit;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = bus.rd_addr[slice_lo(k, AW) +: AW];
      d   = mem[ra];
      hit = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
        if ((BYPASS != 0) && bus.wr_en[i] && (bus.wr_addr[slice_lo(i, AW) +: AW] == ra)) begin
          d   = bus.wr_data[slice_lo(i, DW) +: DW];
          hit = 1'b1;
        end
      end
      // Register 0 is hard-wired: no bypass and never busy.
      if ((ZERO_REG != 0) && (ra == '0)) begin
        d   = '0;
        hit = 1'b0;
      end
      bus.rd_data[slice_lo(k, DW) +: DW] = d;
      bus.rd_busy[k]                     = busy[ra] && !hit;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .busy     (busy),
    .rsv_err  (bus.rsv_err),
    .busy_cnt (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, port priority, bypass, zero register, scoreboard.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after that.
module tb_regfile_mp_sb;
  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [DW-1:0] exp_q[$];

  regfile_mp_sb_if #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  regfile_mp_sb #(
    .DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = '0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en[p]              = 1'b1;
    bus.wr_addr[p*AW +: AW]   = a;
    bus.wr_data[p*DW +: DW]   = d;
  endtask

  task automatic set_rsv(input logic [AW-1:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    bus.rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return bus.rd_data[k*DW +: DW];
  endfunction

  logic [AW-1:0] tbl_addr [4];
  logic [DW-1:0] tbl_data [4];

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rsv_addr  = '0;
    idle();
    tbl_addr[0] = 5'd1;  tbl_data[0] = 32'h0123_4567;
    tbl_addr[1] = 5'd2;  tbl_data[1] = 32'h89AB_CDEF;
    tbl_addr[2] = 5'd30; tbl_data[2] = 32'hCAFE_F00D;
    tbl_addr[3] = 5'd31; tbl_data[3] = 32'h0BAD_BEEF;
    repeat (2) step();
    check("rst_cnt", bus.busy_cnt, 0);
    check("rst_err", bus.rsv_err, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Reset mid-cycle with live data, a busy register and a pending error pulse.
    set_wr(0, 5'd5, 32'hDEAD);
    set_rsv(5'd4);
    step();
    idle();
    set_rsv(5'd4);
    step();
    idle();
    set_rd(0, 5'd5);
    #1;
    check("pre_rst_r5", rd(0), 32'hDEAD);
    check("pre_rst_err", bus.rsv_err, 1);
    check("pre_rst_cnt", bus.busy_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_r5", rd(0), 0);
    check("async_rst_cnt", bus.busy_cnt, 0);
    check("async_rst_err", bus.rsv_err, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Both write ports hit r7: port 1 wins for bypass and for storage.
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    set_rd(1, 5'd7);
    #1;
    check("conflict_bypass", rd(1), 32'h22);
    step();
    idle();
    set_rd(0, 5'd7);
    #1;
    check("conflict_store", rd(0), 32'h22);

    // Bypass of a same-cycle write over older array contents.
    set_wr(0, 5'd3, 32'hAAAA);
    step();
    idle();
    set_rd(0, 5'd3);
    #1;
    check("r3_old", rd(0), 32'hAAAA);
    set_wr(0, 5'd3, 32'h5555);
    #1;
    check("r3_bypass", rd(0), 32'h5555);
    step();
    idle();
    #1;
    check("r3_array", rd(0), 32'h5555);

    // Register 0 ignores writes and reservations.
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    set_rsv(5'd0);
    set_rd(0, 5'd0);
    #1;
    check("r0_no_bypass", rd(0), 0);
    check("r0_busy_comb", bus.rd_busy[0], 0);
    step();
    idle();
    #1;
    check("r0_read", rd(0), 0);
    check("r0_cnt", bus.busy_cnt, 0);
    check("r0_busy", bus.rd_busy[0], 0);
    check("r0_err", bus.rsv_err, 0);

    // Reserve, double-reserve error pulse, writeback release of r9.
    set_rsv(5'd9);
    step();
    idle();
    set_rd(0, 5'd9);
    #1;
    check("r9_busy", bus.rd_busy[0], 1);
    check("r9_cnt", bus.busy_cnt, 1);
    check("r9_err_none", bus.rsv_err, 0);
    set_rsv(5'd9);
    step();
    idle();
    #1;
    check("r9_err_pulse", bus.rsv_err, 1);
    check("r9_cnt_same", bus.busy_cnt, 1);
    step();
    check("r9_err_clear", bus.rsv_err, 0);
    check("r9_still_busy", bus.rd_busy[0], 1);
    set_wr(0, 5'd9, 32'h99);
    #1;
    check("r9_wb_busy", bus.rd_busy[0], 0);
    check("r9_wb_data", rd(0), 32'h99);
    check("r9_wb_cnt_old", bus.busy_cnt, 1);
    step();
    idle();
    #1;
    check("r9_released_cnt", bus.busy_cnt, 0);
    check("r9_released", bus.rd_busy[0], 0);

    // Same-cycle reserve and writeback of busy r12: stays busy, no error.
    set_rsv(5'd12);
    step();
    idle();
    #1;
    check("r12_cnt", bus.busy_cnt, 1);
    set_rsv(5'd12);
    set_wr(1, 5'd12, 32'hC12);
    step();
    idle();
    set_rd(1, 5'd12);
    #1;
    check("r12_err", bus.rsv_err, 0);
    check("r12_cnt_kept", bus.busy_cnt, 1);
    check("r12_busy", bus.rd_busy[1], 1);
    check("r12_data", rd(1), 32'hC12);

    // Writes to non-busy registers, read back through both ports from the expected queue.
    for (int j = 0; j < 4; j += 2) begin
      set_wr(0, tbl_addr[j], tbl_data[j]);
      set_wr(1, tbl_addr[j+1], tbl_data[j+1]);
      exp_q.push_back(tbl_data[j]);
      exp_q.push_back(tbl_data[j+1]);
      step();
      idle();
    end
    #1;
    check("nonbusy_cnt", bus.busy_cnt, 1);
    for (int j = 0; j < 4; j += 2) begin
      set_rd(0, tbl_addr[j]);
      set_rd(1, tbl_addr[j+1]);
      #1;
      check("tbl_rd0", rd(0), exp_q.pop_front());
      check("tbl_rd1", rd(1), exp_q.pop_front());
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
